gemm_tile_controller: RTL

//  Sequencer for the RowPar x ColPar output-stationary MAC array of the GeMM accelerator.

---
 rtl/gemm_tile_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/gemm_tile_controller.sv
// gemm_tile_controller
//   Sequencer for a RowPar x ColPar output-stationary MAC array. At start it latches the
//   M/K/N sizes, then walks the output matrix tile by tile (M-tile outer, N-tile middle,
//   K innermost). It drives the loop counters for A/B address generation, the MAC
//   valid/init pulses, and per-PE C write enables with partial-tile row/col masking.
//
// Ports
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   start_i                 start pulse, only honoured in idle
//   input_valid_i           A/B data available this cycle; low stalls the beat
//   M_size_i/K_size_i/N_size_i  problem sizes, sampled at start
//   m_tile_o/n_tile_o/k_count_o loop counters for A/B address generation
//   mac_valid_o/init_save_o MAC operand valid and accumulator-overwrite pulse
//   c_m_tile_o/c_n_tile_o   tile indices of the tile being written to C
//   c_we_o                  per-PE C write enable, bit r*ColPar+c
//   busy_o/done_o           busy in run/drain, one-cycle completion pulse
module gemm_tile_controller #(
  parameter int unsigned SizeAddrWidth = 8,
  parameter int unsigned RowPar        = 4,
  parameter int unsigned ColPar        = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       input_valid_i,
  input  logic [SizeAddrWidth-1:0]   M_size_i,
  input  logic [SizeAddrWidth-1:0]   K_size_i,
  input  logic [SizeAddrWidth-1:0]   N_size_i,
  output logic [SizeAddrWidth-1:0]   m_tile_o,
  output logic [SizeAddrWidth-1:0]   n_tile_o,
  output logic [SizeAddrWidth-1:0]   k_count_o,
  output logic                       mac_valid_o,
  output logic                       init_save_o,
  output logic [SizeAddrWidth-1:0]   c_m_tile_o,
  output logic [SizeAddrWidth-1:0]   c_n_tile_o,
  output logic [RowPar*ColPar-1:0]   c_we_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned SW   = SizeAddrWidth;
  localparam int unsigned TW   = SizeAddrWidth + 1;
  localparam int unsigned MaxP = (RowPar > ColPar) ? RowPar : ColPar;
  localparam int unsigned MW   = SizeAddrWidth + $clog2(MaxP) + 2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                   state_q;
  logic [SW-1:0]            m_size_q, k_size_q, n_size_q;
  logic [TW-1:0]            mt_q, nt_q;
  logic [SW-1:0]            m_tile_q, n_tile_q, k_q;
  // Stage 1: beat registered alongside the SRAM read
  logic                     v1_q, init1_q, end1_q;
  logic [SW-1:0]            m1_q, n1_q;
  // Stage 2: aligned with the registered MAC output
  logic [RowPar*ColPar-1:0] c_we_q;
  logic [SW-1:0]            c_m_q, c_n_q;
  logic                     done_q;

  logic                     beat, k_last, n_last, m_last, any_zero;
  logic [TW-1:0]            mt_calc, nt_calc;
  logic [RowPar-1:0]        row_valid;
  logic [ColPar-1:0]        col_valid;
  logic [RowPar*ColPar-1:0] we_mask;

  always_comb begin
    beat     = (state_q == StRun) && input_valid_i;
    k_last   = (k_q == k_size_q - SW'(1));
    n_last   = ({1'b0, n_tile_q} == nt_q - TW'(1));
    m_last   = ({1'b0, m_tile_q} == mt_q - TW'(1));
    any_zero = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
    // Extra bit keeps ceil() exact at the maximum size
    mt_calc  = (TW'(M_size_i) + TW'(RowPar - 1)) / TW'(RowPar);
    nt_calc  = (TW'(N_size_i) + TW'(ColPar - 1)) / TW'(ColPar);
  end

  // Edge-tile masks for the tile leaving stage 1
  always_comb begin
    row_valid = '0;
    col_valid = '0;
    we_mask   = '0;
    for (int r = 0; r < RowPar; r++) begin
      row_valid[r] = (MW'(m1_q) * MW'(RowPar) + MW'(r)) < MW'(m_size_q);
    end
    for (int c = 0; c < ColPar; c++) begin
      col_valid[c] = (MW'(n1_q) * MW'(ColPar) + MW'(c)) < MW'(n_size_q);
    end
    for (int r = 0; r < RowPar; r++) begin
      for (int c = 0; c < ColPar; c++) begin
        we_mask[r*ColPar+c] = row_valid[r] & col_valid[c];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      m_size_q <= '0;
      k_size_q <= '0;
      n_size_q <= '0;
      mt_q     <= '0;
      nt_q     <= '0;
      m_tile_q <= '0;
      n_tile_q <= '0;
      k_q      <= '0;
      v1_q     <= 1'b0;
      init1_q  <= 1'b0;
      end1_q   <= 1'b0;
      m1_q     <= '0;
      n1_q     <= '0;
      c_we_q   <= '0;
      c_m_q    <= '0;
      c_n_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      // Pipeline shifts every cycle; idle/stall cycles carry zeros
      v1_q    <= beat;
      init1_q <= beat && (k_q == '0);
      end1_q  <= beat && k_last;
      m1_q    <= m_tile_q;
      n1_q    <= n_tile_q;
      c_we_q  <= end1_q ? we_mask : '0;
      c_m_q   <= m1_q;
      c_n_q   <= n1_q;
      // Registered one cycle after DONE so the pulse trails the final C write
      done_q  <= (state_q == StDone);

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            m_size_q <= M_size_i;
            k_size_q <= K_size_i;
            n_size_q <= N_size_i;
            mt_q     <= mt_calc;
            nt_q     <= nt_calc;
            m_tile_q <= '0;
            n_tile_q <= '0;
            k_q      <= '0;
            state_q  <= any_zero ? StDone : StRun;
          end
        end
        StRun: begin
          if (beat) begin
            if (!k_last) begin
              k_q <= k_q + SW'(1);
            end else if (!n_last) begin
              k_q      <= '0;
              n_tile_q <= n_tile_q + SW'(1);
            end else if (!m_last) begin
              k_q      <= '0;
              n_tile_q <= '0;
              m_tile_q <= m_tile_q + SW'(1);
            end else begin
              // Final beat: counters freeze on the last tile
              state_q <= StDrain;
            end
          end
        end
        // Drain plus the DONE cycle give the two cycles the pipeline needs
        StDrain: state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_tile_o    = m_tile_q;
  assign n_tile_o    = n_tile_q;
  assign k_count_o   = k_q;
  assign mac_valid_o = v1_q;
  assign init_save_o = init1_q;
  assign c_m_tile_o  = c_m_q;
  assign c_n_tile_o  = c_n_q;
  assign c_we_o      = c_we_q;
  assign busy_o      = (state_q == StRun) || (state_q == StDrain);
  assign done_o      = done_q;

endmodule
